// File: rtl/execute_stage.sv
// LC-3 Execute stage: operand forwarding, ALU, address adder and branch-mask
// generation, with all results registered for the Memory/Writeback stages.
module execute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_execute,
  input  logic [5:0]       E_Control,
  input  logic [WIDTH-1:0] IR,
  input  logic [WIDTH-1:0] npc_in,
  input  logic [1:0]       W_Control_in,
  input  logic             Mem_Control_in,
  input  logic [WIDTH-1:0] VSR1,
  input  logic [WIDTH-1:0] VSR2,
  input  logic             bypass_alu_1,
  input  logic             bypass_alu_2,
  input  logic             bypass_mem_1,
  input  logic             bypass_mem_2,
  input  logic [WIDTH-1:0] Mem_Bypass_Val,
  output logic [2:0]       sr1,
  output logic [2:0]       sr2,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] M_Data,
  output logic [2:0]       dr,
  output logic [2:0]       NZP,
  output logic [WIDTH-1:0] IR_Exec,
  output logic [1:0]       W_Control_out,
  output logic             Mem_Control_out
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;

  logic [1:0]       alu_control;
  logic [1:0]       pcselect1;
  logic             pcselect2;
  logic             op2select;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] pc_next;
  logic [2:0]       nzp_next;

  assign alu_control = E_Control[5:4];
  assign pcselect1   = E_Control[3:2];
  assign pcselect2   = E_Control[1];
  assign op2select   = E_Control[0];

  // Stores read their source register through the sr2 port.
  assign sr1 = IR[8:6];
  assign sr2 = (IR[13:12] == 2'b11) ? IR[11:9] : IR[2:0];

  always_comb begin
    // ALU forwarding takes priority: it is the more recent producer.
    if (bypass_alu_1)      val1 = aluout;
    else if (bypass_mem_1) val1 = Mem_Bypass_Val;
    else                   val1 = VSR1;

    if (bypass_alu_2)      val2 = aluout;
    else if (bypass_mem_2) val2 = Mem_Bypass_Val;
    else                   val2 = VSR2;

    op2 = op2select ? val2 : {{(WIDTH-5){IR[4]}}, IR[4:0]};

    case (alu_control)
      2'd0:    alu_next = val1 + op2;
      2'd1:    alu_next = val1 & op2;
      2'd2:    alu_next = ~val1;
      default: alu_next = '0;
    endcase

    case (pcselect1)
      2'd0:    offset = {{(WIDTH-11){IR[10]}}, IR[10:0]};
      2'd1:    offset = {{(WIDTH-9){IR[8]}}, IR[8:0]};
      2'd2:    offset = {{(WIDTH-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase

    base    = pcselect2 ? npc_in : val1;
    pc_next = offset + base;

    if (IR[15:12] == OP_BR)       nzp_next = IR[11:9];
    else if (IR[15:12] == OP_JMP) nzp_next = 3'b111;
    else                          nzp_next = 3'b000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout          <= '0;
      pcout           <= '0;
      M_Data          <= '0;
      dr              <= '0;
      NZP             <= '0;
      IR_Exec         <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
    end else if (enable_execute) begin
      aluout          <= alu_next;
      pcout           <= pc_next;
      M_Data          <= val2;
      dr              <= IR[11:9];
      NZP             <= nzp_next;
      IR_Exec         <= IR;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a reference model predicts each cycle's
// registered outputs, a monitor compares them one clock after issue.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  execute_stage #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .E_Control(E_Control), .IR(IR), .npc_in(npc_in),
    .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
    .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .Mem_Bypass_Val(Mem_Bypass_Val),
    .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .M_Data(M_Data),
    .dr(dr), .NZP(NZP), .IR_Exec(IR_Exec),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] md;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [15:0] ir;
    logic [1:0]  wc;
    logic        mc;
  } exp_t;

  exp_t q[$];
  exp_t st;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned bits);
    logic [15:0] m;
    m = 16'hFFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  // Reference: compute the architectural result of one instruction.
  function automatic exp_t model(input exp_t prev, input logic [15:0] ir, input logic [5:0] ec,
                                 input logic [15:0] npc, input logic [15:0] v1, input logic [15:0] v2,
                                 input logic [3:0] byp, input logic [15:0] mbv,
                                 input logic [1:0] wc, input logic mc);
    exp_t r;
    logic [15:0] a, b, o2, off, bs;
    int unsigned opc;
    a  = byp[3] ? prev.alu : (byp[2] ? mbv : v1);
    b  = byp[1] ? prev.alu : (byp[0] ? mbv : v2);
    o2 = ec[0] ? b : sext(ir, 5);
    case (ec[5:4])
      2'd0: r.alu = 16'((int'(a) + int'(o2)) % 65536);
      2'd1: r.alu = a & o2;
      2'd2: r.alu = 16'hFFFF - a;
      default: r.alu = 16'h0000;
    endcase
    case (ec[3:2])
      2'd0: off = sext(ir, 11);
      2'd1: off = sext(ir, 9);
      2'd2: off = sext(ir, 6);
      default: off = 16'h0000;
    endcase
    bs   = ec[1] ? npc : a;
    r.pc = 16'((int'(off) + int'(bs)) % 65536);
    r.md = b;
    r.dr = ir[11:9];
    opc  = int'(ir[15:12]);
    r.nzp = (opc == 0) ? ir[11:9] : ((opc == 12) ? 3'b111 : 3'b000);
    r.ir = ir;
    r.wc = wc;
    r.mc = mc;
    return r;
  endfunction

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2, input logic [3:0] byp,
                       input logic [15:0] mbv, input logic [1:0] wc, input logic mc, input logic en);
    logic [2:0] e_sr2;
    @(negedge clock);
    IR = ir; E_Control = ec; npc_in = npc; VSR1 = v1; VSR2 = v2;
    {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
    Mem_Bypass_Val = mbv; W_Control_in = wc; Mem_Control_in = mc; enable_execute = en;
    if (en) st = model(st, ir, ec, npc, v1, v2, byp, mbv, wc, mc);
    q.push_back(st);
    #1;
    e_sr2 = (ir[13:12] == 2'b11) ? ir[11:9] : ir[2:0];
    chk("sr1", {13'd0, sr1}, {13'd0, ir[8:6]});
    chk("sr2", {13'd0, sr2}, {13'd0, e_sr2});
  endtask

  task automatic after_edge();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " aluout"}, aluout, 16'h0);
    chk({tag, " pcout"}, pcout, 16'h0);
    chk({tag, " M_Data"}, M_Data, 16'h0);
    chk({tag, " dr"}, {13'd0, dr}, 16'h0);
    chk({tag, " NZP"}, {13'd0, NZP}, 16'h0);
    chk({tag, " IR_Exec"}, IR_Exec, 16'h0);
    chk({tag, " W_Control_out"}, {14'd0, W_Control_out}, 16'h0);
    chk({tag, " Mem_Control_out"}, {15'd0, Mem_Control_out}, 16'h0);
  endtask

  // Monitor: every clock edge with an issued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("aluout", aluout, e.alu);
        chk("pcout", pcout, e.pc);
        chk("M_Data", M_Data, e.md);
        chk("dr", {13'd0, dr}, {13'd0, e.dr});
        chk("NZP", {13'd0, NZP}, {13'd0, e.nzp});
        chk("IR_Exec", IR_Exec, e.ir);
        chk("W_Control_out", {14'd0, W_Control_out}, {14'd0, e.wc});
        chk("Mem_Control_out", {15'd0, Mem_Control_out}, {15'd0, e.mc});
      end
    end
  end

  initial begin
    st = '0;
    reset = 1'b1; enable_execute = 1'b0; E_Control = '0; IR = '0; npc_in = '0;
    VSR1 = '0; VSR2 = '0; Mem_Bypass_Val = '0; W_Control_in = '0; Mem_Control_in = 1'b0;
    bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // ADD R3,R1,#-2
    drive(16'h167E, 6'h00, 16'h0000, 16'h0005, 16'h0000, 4'b0000, 16'h0, 2'd1, 1'b0, 1'b1);
    after_edge();
    chk("t1 aluout", aluout, 16'h0003);
    chk("t1 dr", {13'd0, dr}, 16'd3);
    chk("t1 NZP", {13'd0, NZP}, 16'd0);
    // AND R0,R1,R2
    drive(16'h5042, 6'h11, 16'h0000, 16'h00FF, 16'h0F0F, 4'b0000, 16'h0, 2'd0, 1'b0, 1'b1);
    after_edge();
    chk("t2 aluout", aluout, 16'h000F);
    // BRnp #5
    drive(16'h0A05, 6'h07, 16'h3001, 16'h0000, 16'h0000, 4'b0000, 16'h0, 2'd0, 1'b0, 1'b1);
    after_edge();
    chk("t3 pcout", pcout, 16'h3006);
    chk("t3 NZP", {13'd0, NZP}, 16'd5);
    // LDR R2,R3,#-2
    drive(16'h64FE, 6'h08, 16'h0000, 16'h4000, 16'h0000, 4'b0000, 16'h0, 2'd2, 1'b1, 1'b1);
    after_edge();
    chk("t4 pcout", pcout, 16'h3FFE);
    chk("t4 W_Control_out", {14'd0, W_Control_out}, 16'd2);
    // Address wrap-around: base 0xFFFF, offset +2
    drive(16'h6082, 6'h08, 16'h0000, 16'hFFFF, 16'h0000, 4'b0000, 16'h0, 2'd0, 1'b0, 1'b1);
    after_edge();
    chk("wrap pcout", pcout, 16'h0001);

    // Forwarding chain
    drive(16'h167E, 6'h00, 16'h0000, 16'h0005, 16'h0000, 4'b0000, 16'h0, 2'd1, 1'b0, 1'b1);
    drive(16'h18E1, 6'h00, 16'h0000, 16'hDEAD, 16'h0000, 4'b1000, 16'h0, 2'd1, 1'b0, 1'b1);
    after_edge();
    chk("fwd alu aluout", aluout, 16'h0004);
    drive(16'h18E1, 6'h00, 16'h0000, 16'hDEAD, 16'h0000, 4'b0100, 16'h0010, 2'd1, 1'b0, 1'b1);
    after_edge();
    chk("fwd mem aluout", aluout, 16'h0011);
    drive(16'h18E1, 6'h00, 16'h0000, 16'hDEAD, 16'h0000, 4'b1100, 16'h0010, 2'd1, 1'b0, 1'b1);
    after_edge();
    chk("fwd both aluout", aluout, 16'h0012);

    // Stall three cycles with changing inputs
    for (int i = 0; i < 3; i++)
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    after_edge();
    chk("stall aluout", aluout, 16'h0012);

    // Reset asserted mid-stall clears outputs before the next edge
    @(negedge clock);
    enable_execute = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("async reset");
    #1 reset = 1'b0;
    st = '0;

    for (int i = 0; i < 400; i++)
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(0, 5) != 0);

    repeat (3) @(negedge clock);
    chk("scoreboard drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipelined LC-3 Execute stage, directly downstream of the Decode stage. Consumes Decode's registered IR, npc, E_Control, W_Control and Mem_Control.
- Computes the ALU result, the effective/branch address, store data and branch-condition mask.
- Registers all results for the Memory/Writeback stages.
- Supplies source-register indices combinationally to the register file and accepts bypass controls from the hazard unit.

Parameters:
- WIDTH, 16, datapath width (only 16 is supported).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable_execute  input  1  stage advance; when low, all registers hold
- E_Control  input  6  {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]} from Decode
- IR  input  16  instruction from Decode
- npc_in  input  16  next PC from Decode
- W_Control_in  input  2  writeback select from Decode
- Mem_Control_in  input  1  indirect-memory flag from Decode
- VSR1  input  16  register-file value at sr1
- VSR2  input  16  register-file value at sr2
- bypass_alu_1, bypass_alu_2  input  1 each  replace operand 1/2 with own registered aluout
- bypass_mem_1, bypass_mem_2  input  1 each  replace operand 1/2 with Mem_Bypass_Val
- Mem_Bypass_Val  input  16  value forwarded from the Memory stage
- sr1  output  3  IR[8:6], combinational
- sr2  output  3  IR[11:9] if IR[13:12]==2'b11 (store), else IR[2:0]; combinational
- aluout  output  16  registered ALU result
- pcout  output  16  registered address/branch target
- M_Data  output  16  registered store data
- dr  output  3  registered destination register IR[11:9]
- NZP  output  3  registered branch-condition mask
- IR_Exec  output  16  registered copy of IR
- W_Control_out  output  2  registered W_Control_in
- Mem_Control_out  output  1  registered Mem_Control_in

Behaviour:
- Reset: asynchronous; while reset is high, every registered output is 0. sr1/sr2 stay combinational.
- Latency: exactly 1 cycle. Inputs present before edge N appear on the outputs after edge N when enable_execute=1.
- enable_execute=0: every register holds its value, including after multiple stalled cycles. Combinational sr1/sr2 still track IR.
- Operand selection, val1: bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1. ALU bypass wins if both are set.
- Operand selection, val2: same rule using bypass_alu_2, bypass_mem_2 and VSR2.
- op2 = op2select ? val2 : sext(IR[4:0]).
- ALU:
  - alu_control 0: val1+op2, mod 2^16, no carry out.
  - alu_control 1: val1 & op2.
  - alu_control 2: ~val1.
  - alu_control 3: aluout registers 0.
- Address adder, offset term by pcselect1: 0 sext(IR[10:0]); 1 sext(IR[8:0]); 2 sext(IR[5:0]); 3 16'h0000.
- Address adder, base term: pcselect2 ? npc_in : val1.
- pcout = offset + base, mod 2^16. Wrap-around is silent, e.g. 16'hFFFF + 2 gives 16'h0001.
- M_Data <= val2. This is the store source register, since sr2 selects IR[11:9] for stores.
- dr <= IR[11:9].
- NZP:
  - IR[15:12]==4'b0000 (BR): IR[11:9].
  - IR[15:12]==4'b1100 (JMP): 3'b111.
  - Otherwise: 3'b000.
- Pass-through: IR_Exec, W_Control_out and Mem_Control_out register their inputs unchanged.
- Reset asserted mid-stall or mid-operation: outputs clear immediately, without waiting for a clock edge. The first enabled edge after reset deassertion captures fresh inputs.
- Bypass and self-forwarding: bypass_alu_x uses the value currently on aluout, i.e. the previous instruction's result. Back-to-back dependent ALU ops therefore complete without a stall.

Test Plan:
1. ADD R3,R1,#-2: IR=16'h167E, E_Control=6'h00, VSR1=16'h0005, enable=1 -> after 1 edge: aluout=16'h0003, dr=3, sr1=1 combinationally, NZP=0.
2. AND R0,R1,R2: IR=16'h5042, E_Control=6'h11, VSR1=16'h00FF, VSR2=16'h0F0F -> aluout=16'h000F, sr2=2.
3. BRnp #5: IR=16'h0A05, E_Control=6'h07, npc_in=16'h3001 -> pcout=16'h3006, NZP=3'b101.
4. LDR R2,R3,#-2: IR=16'h64FE, E_Control=6'h08, VSR1=16'h4000 -> pcout=16'h3FFE, W_Control_out tracks W_Control_in.
5. Forwarding: apply test 1, then ADD R4,R3,#1 (IR=16'h18E1, E_Control=6'h00) with bypass_alu_1=1 and VSR1=16'hDEAD -> aluout=16'h0004.
   - Repeat with bypass_mem_1=1 only and Mem_Bypass_Val=16'h0010 -> aluout=16'h0011.
   - Set both bypass_alu_1 and bypass_mem_1 -> the aluout path wins.
6. Stall and reset: hold enable_execute=0 for 3 cycles while changing inputs -> all outputs unchanged. Assert reset between edges -> all registered outputs go to 0 before the next edge.
